// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiplier / divider datapath.
// Lane geometry, sign encodings and the partial-product sideband bundle.
package mul_div_pkg;

   localparam int MUL_LANE_W    = 64;
   localparam int MUL_NUM_LANES = 16;
   localparam int MUL_TAG_W     = 4;

   // {rs1_signed, rs2_signed}
   localparam logic [1:0] SGN_UU = 2'b00;
   localparam logic [1:0] SGN_SU = 2'b10;
   localparam logic [1:0] SGN_SS = 2'b11;

   // Sideband that travels with every partial-product bundle
   typedef struct packed {
      logic [1:0]           sign;
      logic                 higher;
      logic [MUL_TAG_W-1:0] tag;
   } mul_pp_side_t;

   typedef enum logic [1:0] {
      PP_EMPTY = 2'd0,
      PP_ONE   = 2'd1,
      PP_FULL  = 2'd2
   } mul_pp_state_e;

endpackage

// File: rtl/mul_pp_slot.sv
// One payload register of the partial-product skid stage.
// Loads only on load_i; optional reset of the payload bits.
module mul_pp_slot
   import mul_div_pkg::*;
#(
   parameter int W          = 8,
   parameter bit RESET_DATA = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   if (RESET_DATA) begin : g_rst
      // Payload register, cleared by reset
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q <= '0;
         end else if (load_i) begin
            data_q <= d_i;
         end
      end
   end else begin : g_norst
      // Payload register without reset; contents meaningless until loaded
      always_ff @(posedge clk) begin
         if (load_i) begin
            data_q <= d_i;
         end
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/mul_pp_skid_stage.sv
// Elastic 2-entry skid stage between partial-product generation and the
// reduction tree. MAIN drives the outputs, SKID absorbs one overflow op.
module mul_pp_skid_stage
   import mul_div_pkg::*;
#(
   parameter int LANE_W     = MUL_LANE_W,
   parameter int NUM_LANES  = MUL_NUM_LANES,
   parameter int TAG_W      = MUL_TAG_W,
   parameter bit RESET_DATA = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [NUM_LANES*LANE_W-1:0] in_partial_i,
   input  logic [1:0]                  in_sign_i,
   input  logic                        in_higher_i,
   input  logic [TAG_W-1:0]            in_tag_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [NUM_LANES*LANE_W-1:0] out_partial_o,
   output logic [1:0]                  out_sign_o,
   output logic                        out_higher_o,
   output logic [TAG_W-1:0]            out_tag_o,
   output logic [1:0]                  occupancy_o
);

   // The sideband tag width follows the shared package definition.
   localparam int PP_W  = NUM_LANES * LANE_W;
   localparam int SD_W  = $bits(mul_pp_side_t);
   localparam int PAY_W = PP_W + SD_W;

   mul_pp_state_e state_q, state_d;
   logic          ready_q, ready_d;

   logic accept;
   logic emit;
   logic main_ld;
   logic skid_ld;
   logic main_from_skid;

   mul_pp_side_t     in_side;
   mul_pp_side_t     out_side;
   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] main_d;
   logic [PAY_W-1:0] main_q;
   logic [PAY_W-1:0] skid_q;

   assign out_valid_o = (state_q != PP_EMPTY);
   assign in_ready_o  = ready_q;
   assign occupancy_o = state_q;

   assign accept = in_valid_i & ready_q;
   assign emit   = out_valid_o & out_ready_i;

   // Pack incoming op into one payload word
   always_comb begin
      in_side        = '0;
      in_side.sign   = in_sign_i;
      in_side.higher = in_higher_i;
      in_side.tag    = in_tag_i;
      in_pay         = {in_partial_i, in_side};
   end

   // Next-state and slot write enables; flush overrides everything
   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      unique case (state_q)
         PP_EMPTY: begin
            if (accept) begin
               main_ld = 1'b1;
               state_d = PP_ONE;
            end
         end
         PP_ONE: begin
            if (accept && emit) begin
               main_ld = 1'b1;
            end else if (accept) begin
               skid_ld = 1'b1;
               state_d = PP_FULL;
            end else if (emit) begin
               state_d = PP_EMPTY;
            end
         end
         PP_FULL: begin
            if (emit) begin
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
               state_d        = PP_ONE;
            end
         end
         default: begin
            state_d = PP_EMPTY;
         end
      endcase
      if (flush_i) begin
         state_d = PP_EMPTY;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
      ready_d = (state_d != PP_FULL);
   end

   // Control state and registered upstream ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PP_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
      end
   end

   // MAIN refills from SKID when draining a FULL stage
   always_comb begin
      main_d = main_from_skid ? skid_q : in_pay;
   end

   mul_pp_slot #(
      .W          (PAY_W),
      .RESET_DATA (RESET_DATA)
   ) u_main (
      .clk    (clk),
      .rst    (rst),
      .load_i (main_ld),
      .d_i    (main_d),
      .q_o    (main_q)
   );

   mul_pp_slot #(
      .W          (PAY_W),
      .RESET_DATA (RESET_DATA)
   ) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load_i (skid_ld),
      .d_i    (in_pay),
      .q_o    (skid_q)
   );

   assign out_side      = mul_pp_side_t'(main_q[SD_W-1:0]);
   assign out_partial_o = main_q[PAY_W-1:SD_W];
   assign out_sign_o    = out_side.sign;
   assign out_higher_o  = out_side.higher;
   assign out_tag_o     = out_side.tag;

endmodule

// File: tb/tb_mul_pp_skid_stage.sv
// Directed and scoreboard bench for mul_pp_skid_stage.
module tb_mul_pp_skid_stage;
   import mul_div_pkg::*;

   localparam int LW = 64;
   localparam int NL = 16;
   localparam int TW = 4;
   localparam int PW = NL * LW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush_i = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [PW-1:0] in_partial_i = '0;
   logic [1:0]    in_sign_i = '0;
   logic          in_higher_i = 1'b0;
   logic [TW-1:0] in_tag_i = '0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [PW-1:0] out_partial_o;
   logic [1:0]    out_sign_o;
   logic          out_higher_o;
   logic [TW-1:0] out_tag_o;
   logic [1:0]    occupancy_o;

   int errors = 0;
   int checks = 0;

   mul_pp_skid_stage #(
      .LANE_W(LW), .NUM_LANES(NL), .TAG_W(TW), .RESET_DATA(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_partial_i(in_partial_i), .in_sign_i(in_sign_i),
      .in_higher_i(in_higher_i), .in_tag_i(in_tag_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_partial_o(out_partial_o), .out_sign_o(out_sign_o),
      .out_higher_o(out_higher_o), .out_tag_o(out_tag_o),
      .occupancy_o(occupancy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] mk(input logic [31:0] id);
      logic [PW-1:0] r;
      r = '0;
      for (int k = 0; k < NL; k++) r[k*LW +: LW] = {id, 32'(k)};
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Full payload check of the op currently shown at the output
   task automatic chk_op(input string name, input logic [31:0] id);
      checks++;
      if (out_partial_o !== mk(id) || out_tag_o !== id[TW-1:0] ||
          out_sign_o !== id[1:0] || out_higher_o !== id[2]) begin
         errors++;
         $display("FAIL %s: got tag %0h sign %0h hi %0b lane0 %0h expected id %0h",
                  name, out_tag_o, out_sign_o, out_higher_o,
                  out_partial_o[LW-1:0], id);
      end
   endtask

   task automatic drive(input logic v, input logic r, input logic f,
                        input logic [31:0] id);
      in_valid_i   = v;
      out_ready_i  = r;
      flush_i      = f;
      in_partial_i = mk(id);
      in_tag_i     = id[TW-1:0];
      in_sign_i    = id[1:0];
      in_higher_i  = id[2];
   endtask

   typedef struct {
      logic        v, r, f;
      logic [31:0] id;
      logic        ov, ir;
      logic [1:0]  occ;
      logic [31:0] oid;
   } vec_t;

   vec_t tbl[18];
   logic [31:0] q[$];

   initial begin
      // inputs this cycle -> outputs observed in this cycle, before the edge
      tbl[0]  = '{0,0,0, 0, 0,1,0, 0};
      tbl[1]  = '{1,1,0, 1, 0,1,0, 0};
      tbl[2]  = '{1,1,0, 2, 1,1,1, 1};
      tbl[3]  = '{1,1,0, 3, 1,1,1, 2};
      tbl[4]  = '{0,1,0, 0, 1,1,1, 3};
      tbl[5]  = '{0,0,0, 0, 0,1,0, 0};
      tbl[6]  = '{1,0,0, 4, 0,1,0, 0};
      tbl[7]  = '{1,0,0, 5, 1,1,1, 4};
      tbl[8]  = '{1,0,0, 6, 1,0,2, 4};
      tbl[9]  = '{1,1,0, 6, 1,0,2, 4};
      tbl[10] = '{1,1,0, 6, 1,1,1, 5};
      tbl[11] = '{0,0,0, 0, 1,1,1, 6};
      tbl[12] = '{1,0,0, 7, 1,1,1, 6};
      tbl[13] = '{1,0,1, 8, 1,0,2, 6};
      tbl[14] = '{0,1,0, 0, 0,1,0, 0};
      tbl[15] = '{1,0,0, 9, 0,1,0, 0};
      tbl[16] = '{1,0,1, 10, 1,1,1, 9};
      tbl[17] = '{0,1,0, 0, 0,1,0, 0};

      // reset and idle state
      drive(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      chk("rst_ready", 64'(in_ready_o), 64'd1);
      chk("rst_occ", 64'(occupancy_o), 64'd0);
      checks++;
      if (out_partial_o !== '0) begin
         errors++;
         $display("FAIL rst_partial: got %0h expected 0", out_partial_o[LW-1:0]);
      end

      // directed table: streaming, stall, flush in FULL and in ONE
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].id);
         #1;
         chk($sformatf("t%0d_valid", i), 64'(out_valid_o), 64'(tbl[i].ov));
         chk($sformatf("t%0d_ready", i), 64'(in_ready_o), 64'(tbl[i].ir));
         chk($sformatf("t%0d_occ", i), 64'(occupancy_o), 64'(tbl[i].occ));
         if (tbl[i].ov) chk_op($sformatf("t%0d_op", i), tbl[i].oid);
      end

      // back-to-back stream of tags 1..8, each visible one cycle after accept
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         drive(i <= 8, 1, 0, 32'(i));
         #1;
         chk($sformatf("s%0d_valid", i), 64'(out_valid_o), 64'(i > 1));
         if (i > 1) chk_op($sformatf("s%0d_op", i), 32'(i - 1));
      end
      @(negedge clk);
      drive(0, 0, 0, 0);
      #1;
      chk("s_drain_occ", 64'(occupancy_o), 64'd0);

      // randomized handshake, scoreboard ordering and bit-exactness
      begin
         int unsigned seq_in = 1;
         int unsigned n_out = 0;
         int cycles = 0;
         while (n_out < 1000 && cycles < 20000) begin
            @(negedge clk);
            drive((seq_in <= 1000) && ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 1) == 1, 0, seq_in);
            #1;
            chk("rnd_occ", 64'(occupancy_o), 64'(q.size()));
            if (out_valid_o && out_ready_i) begin
               if (q.size() == 0) begin
                  chk("rnd_spurious", 64'(out_tag_o), 64'hdead);
               end else begin
                  chk_op("rnd_op", q[0]);
                  void'(q.pop_front());
               end
               n_out++;
            end
            if (in_valid_i && in_ready_o) begin
               q.push_back(seq_in);
               seq_in++;
            end
            cycles++;
         end
         chk("rnd_count", 64'(n_out), 64'd1000);
         @(negedge clk);
         drive(0, 0, 0, 0);
      end

      // async reset while FULL and stalled
      @(negedge clk);
      drive(1, 0, 0, 32'h21);
      @(negedge clk);
      drive(1, 0, 0, 32'h22);
      @(negedge clk);
      drive(0, 0, 0, 0);
      #1;
      chk("ar_pre_occ", 64'(occupancy_o), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", 64'(out_valid_o), 64'd0);
      chk("ar_ready", 64'(in_ready_o), 64'd1);
      chk("ar_occ", 64'(occupancy_o), 64'd0);
      chk("ar_tag", 64'(out_tag_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drive(1, 1, 0, 32'h33);
      #1;
      chk("ar_resume_idle", 64'(out_valid_o), 64'd0);
      @(negedge clk);
      drive(0, 1, 0, 0);
      #1;
      chk("ar_resume_valid", 64'(out_valid_o), 64'd1);
      chk_op("ar_resume_op", 32'h33);
      @(negedge clk);
      #1;
      chk("ar_resume_occ", 64'(occupancy_o), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
